// File: rtl/tp02_pkg.sv
// Shared types and constants for the TP02 serializer slice:
// FSM state encoding, default operand width and the counter-width helper.
package tp02_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SETUP,
    STROBE,
    DONE
  } state_t;

  localparam int TP02_WIDTH = 4;

  // Bits needed to count 0..w inclusive.
  function automatic int cntWidth(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/tp02_serializer_if.sv
// Bus between a frame producer (master) and the TP02 serializer (slave):
// load request with the two operand words going in, the serial stream,
// strobe and status flags coming out.
import tp02_pkg::*;

interface tp02_serializer_if #(
  parameter int WIDTH = TP02_WIDTH
) ();

  logic             load;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic             start;
  logic             in1;
  logic             in2;
  logic             controle;
  logic             busy;
  logic             done;

  modport master (
    output load, a_data, b_data,
    input  start, in1, in2, controle, busy, done
  );

  modport slave (
    input  load, a_data, b_data,
    output start, in1, in2, controle, busy, done
  );

endinterface

// File: rtl/tp02_serializer_shreg.sv
// WIDTH-bit parallel-load shift register. bit_o always shows the bit that
// goes out next; MSB_FIRST picks which end that is. Vacated bits fill with 0.
import tp02_pkg::*;

module tp02_shreg #(
  parameter int WIDTH     = TP02_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load wins over shift; otherwise hold the current contents.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = MSB_FIRST ? (data_q << 1) : (data_q >> 1);
    end
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bit_o = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/tp02_serializer.sv
// TP02 serializer top: captures two operand words on load and streams them
// bit-serially on in1/in2, each bit framed by a controle 0->1 pair, with a
// start marker before and a done pulse after the frame.
// Optional build macro TP02_SER_PARITY_EN appends one even-parity bit pair.
// All outputs are registered and reflect the state of the previous cycle.
import tp02_pkg::*;

module tp02_serializer #(
  parameter int WIDTH     = TP02_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  tp02_serializer_if.slave bus
);

  localparam int            CW   = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          start_q;
  logic          in1_q;
  logic          in2_q;
  logic          controle_q;
  logic          busy_q;
  logic          done_q;

  logic          loadEn;
  logic          shiftEn;
  logic          bitA;
  logic          bitB;

`ifdef TP02_SER_PARITY_EN
  logic          parA_q;
  logic          parB_q;
  logic          parPhase_q;
`endif

  // A request is taken only in IDLE and not in the cycle showing done,
  // so back-to-back frames need load in the following IDLE cycle.
  assign loadEn  = (state_q == IDLE) && bus.load && !done_q;
  assign shiftEn = (state_q == STROBE) && (cnt_q != LAST);

  tp02_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) uShregA (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (loadEn),
    .shift_i(shiftEn),
    .data_i (bus.a_data),
    .bit_o  (bitA)
  );

  tp02_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) uShregB (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (loadEn),
    .shift_i(shiftEn),
    .data_i (bus.b_data),
    .bit_o  (bitB)
  );

  // Frame sequencer with registered outputs; reset aborts any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      in1_q      <= 1'b0;
      in2_q      <= 1'b0;
      controle_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef TP02_SER_PARITY_EN
      parA_q     <= 1'b0;
      parB_q     <= 1'b0;
      parPhase_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          start_q    <= 1'b0;
          in1_q      <= 1'b0;
          in2_q      <= 1'b0;
          controle_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          if (loadEn) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= START;
`ifdef TP02_SER_PARITY_EN
            parA_q     <= ^bus.a_data;
            parB_q     <= ^bus.b_data;
            parPhase_q <= 1'b0;
`endif
          end
        end
        START: begin
          start_q    <= 1'b1;
          in1_q      <= 1'b0;
          in2_q      <= 1'b0;
          controle_q <= 1'b0;
          state_q    <= SETUP;
        end
        SETUP: begin
          start_q    <= 1'b0;
          controle_q <= 1'b0;
          in1_q      <= bitA;
          in2_q      <= bitB;
`ifdef TP02_SER_PARITY_EN
          if (parPhase_q) begin
            in1_q <= parA_q;
            in2_q <= parB_q;
          end
`endif
          state_q    <= STROBE;
        end
        STROBE: begin
          controle_q <= 1'b1;
          if (cnt_q == LAST) begin
`ifdef TP02_SER_PARITY_EN
            if (!parPhase_q) begin
              parPhase_q <= 1'b1;
              state_q    <= SETUP;
            end else begin
              state_q <= DONE;
            end
`else
            state_q <= DONE;
`endif
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= SETUP;
          end
        end
        DONE: begin
          done_q     <= 1'b1;
          controle_q <= 1'b0;
          in1_q      <= 1'b0;
          in2_q      <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.start    = start_q;
  assign bus.in1      = in1_q;
  assign bus.in2      = in2_q;
  assign bus.controle = controle_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_tp02_serializer.sv
// Self-checking bench for tp02_serializer. Two instances run in lockstep,
// one MSB-first and one LSB-first, fed identical stimulus. Each frame issued
// pushes its expected bit sequences and start/done cycles into a scoreboard;
// a negedge monitor compares everything the DUTs present against it.
// Build with +define+TP02_SER_PARITY_EN to exercise the parity pair.
module tb_tp02_serializer;

  localparam int W = tp02_pkg::TP02_WIDTH;
`ifdef TP02_SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    logic [16:0] m1;
    logic [16:0] m2;
    logic [16:0] l1;
    logic [16:0] l2;
    int          nBits;
    int          startCyc;
    int          doneCyc;
  } frame_t;

  logic   clk = 1'b0;
  logic   rst_n;
  int     cyc = 0;

  frame_t frameQ[$];
  int     framesExpected = 0;
  int     framesSeen = 0;
  int     timeoutCnt = 0;
  int     nChecks = 0;
  int     nFails = 0;
  logic   finalReq = 1'b0;
  logic   finalDone = 1'b0;

  int     idx[2];
  logic   doneSeen[2];
  logic   pCtl[2];
  logic   pIn1[2];
  logic   pIn2[2];
  string  dn[2] = '{"msb", "lsb"};
  frame_t fr;
  logic [1:0] expBits;

  tp02_serializer_if #(.WIDTH(W)) busM ();
  tp02_serializer_if #(.WIDTH(W)) busL ();

  tp02_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutM (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busM)
  );

  tp02_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutL (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busL)
  );

  logic [1:0] oStart, oIn1, oIn2, oCtl, oBusy, oDone;
  assign oStart = {busL.start,    busM.start};
  assign oIn1   = {busL.in1,      busM.in1};
  assign oIn2   = {busL.in2,      busM.in2};
  assign oCtl   = {busL.controle, busM.controle};
  assign oBusy  = {busL.busy,     busM.busy};
  assign oDone  = {busL.done,     busM.done};

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Cycle index: value k after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Expected frame straight from the serialization rules: bit order by
  // direction, optional even parity, start one cycle after acceptance and
  // done two cycles per bit after that.
  function automatic frame_t makeFrame(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
    frame_t f;
    f.m1 = '0;
    f.m2 = '0;
    f.l1 = '0;
    f.l2 = '0;
    for (int i = 0; i < W; i++) begin
      f.m1[i] = a[W-1-i];
      f.m2[i] = b[W-1-i];
      f.l1[i] = a[i];
      f.l2[i] = b[i];
    end
    f.nBits = W + PAR;
    if (PAR != 0) begin
      f.m1[W] = ^a;
      f.m2[W] = ^b;
      f.l1[W] = ^a;
      f.l2[W] = ^b;
    end
    f.startCyc = c + 2;
    f.doneCyc  = c + 3 + 2 * f.nBits;
    return f;
  endfunction

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard monitor: samples both DUTs on the falling edge.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        checkOutput({dn[g], "/reset_outputs"},
                    {26'd0, oStart[g], oIn1[g], oIn2[g], oCtl[g], oBusy[g], oDone[g]}, 32'd0);
        idx[g]      = 0;
        doneSeen[g] = 1'b0;
      end else if (frameQ.size() == 0) begin
        checkOutput({dn[g], "/idle_outputs"},
                    {26'd0, oStart[g], oIn1[g], oIn2[g], oCtl[g], oBusy[g], oDone[g]}, 32'd0);
      end else begin
        fr = frameQ[0];
        if (oStart[g]) begin
          checkOutput({dn[g], "/start_cycle"}, cyc, fr.startCyc);
          checkOutput({dn[g], "/busy_at_start"}, {31'd0, oBusy[g]}, 32'd1);
        end
        if (oCtl[g]) begin
          checkOutput({dn[g], "/strobe_hold"}, {29'd0, pCtl[g], pIn1[g], pIn2[g]},
                      {29'd0, 1'b0, oIn1[g], oIn2[g]});
          if (idx[g] < fr.nBits) begin
            expBits = (g == 0) ? {fr.m1[idx[g]], fr.m2[idx[g]]} : {fr.l1[idx[g]], fr.l2[idx[g]]};
            checkOutput({dn[g], "/serial_bits"}, {30'd0, oIn1[g], oIn2[g]}, {30'd0, expBits});
          end else begin
            checkOutput({dn[g], "/extra_strobe"}, idx[g], fr.nBits);
          end
          idx[g]++;
        end
        if (oDone[g]) begin
          checkOutput({dn[g], "/done_cycle"}, cyc, fr.doneCyc);
          checkOutput({dn[g], "/bit_count"}, idx[g], fr.nBits);
          checkOutput({dn[g], "/busy_at_done"}, {31'd0, oBusy[g]}, 32'd1);
          doneSeen[g] = 1'b1;
        end
      end
      pCtl[g] = oCtl[g];
      pIn1[g] = oIn1[g];
      pIn2[g] = oIn2[g];
    end
    if (doneSeen[0] && doneSeen[1]) begin
      void'(frameQ.pop_front());
      framesSeen++;
      for (int g = 0; g < 2; g++) begin
        doneSeen[g] = 1'b0;
        idx[g]      = 0;
      end
    end
    if (finalReq && !finalDone) begin
      checkOutput("frames_completed", framesSeen, framesExpected);
      checkOutput("wait_timeouts", timeoutCnt, 0);
      checkOutput("scoreboard_empty", frameQ.size(), 0);
      finalDone = 1'b1;
    end
  end

  task automatic driveInputs(input logic l, input logic [W-1:0] a, input logic [W-1:0] b);
    busM.load   = l;
    busM.a_data = a;
    busM.b_data = b;
    busL.load   = l;
    busL.a_data = a;
    busL.b_data = b;
  endtask

  task automatic waitIdle();
    for (int t = 0; t < 100 && frameQ.size() != 0; t++) @(negedge clk);
    if (frameQ.size() != 0) begin
      timeoutCnt++;
      $display("[TB] timeout waiting for frame completion at cycle %0d", cyc);
      frameQ.delete();
    end
  endtask

  // One frame; noiseDelay>0 pulses a stray load that many cycles after acceptance.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int noiseDelay,
                               input logic [W-1:0] na, input logic [W-1:0] nb);
    @(negedge clk);
    frameQ.push_back(makeFrame(a, b, cyc));
    framesExpected++;
    driveInputs(1'b1, a, b);
    @(negedge clk);
    driveInputs(1'b0, a, b);
    if (noiseDelay > 0) begin
      repeat (noiseDelay - 1) @(negedge clk);
      driveInputs(1'b1, na, nb);
      @(negedge clk);
      driveInputs(1'b0, na, nb);
    end
    waitIdle();
  endtask

  // Stimulus sequence.
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           nd;

    driveInputs(1'b0, '0, '0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] directed frames");
    applyStimulus(4'b0011, 4'b1100, 0, '0, '0);
    applyStimulus(4'b0001, 4'b1000, 0, '0, '0);
    applyStimulus(4'b0101, 4'b0011, 5, 4'b1111, 4'b1111);
    applyStimulus(4'b0111, 4'b0101, 0, '0, '0);

    $display("[TB] reset during third strobe");
    @(negedge clk);
    frameQ.push_back(makeFrame(4'b1010, 4'b0110, cyc));
    driveInputs(1'b1, 4'b1010, 4'b0110);
    @(posedge clk);
    #1 driveInputs(1'b0, '0, '0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 frameQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1001, 4'b0110, 0, '0, '0);

    $display("[TB] load during done cycle then back-to-back");
    @(negedge clk);
    frameQ.push_back(makeFrame(4'b1100, 4'b0101, cyc));
    framesExpected++;
    driveInputs(1'b1, 4'b1100, 4'b0101);
    @(negedge clk);
    driveInputs(1'b0, '0, '0);
    for (int t = 0; t < 100 && busM.done !== 1'b1; t++) @(negedge clk);
    if (busM.done !== 1'b1) begin
      timeoutCnt++;
      $display("[TB] timeout waiting for done at cycle %0d", cyc);
    end
    driveInputs(1'b1, 4'b1110, 4'b0001);
    @(negedge clk);
    frameQ.push_back(makeFrame(4'b0001, 4'b1110, cyc));
    framesExpected++;
    driveInputs(1'b1, 4'b0001, 4'b1110);
    @(negedge clk);
    driveInputs(1'b0, '0, '0);
    waitIdle();

    $display("[TB] random frames");
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      nd = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * W + 2)) : 0;
      applyStimulus(ra, rb, nd, W'($urandom), W'($urandom));
    end

    finalReq = 1'b1;
    for (int t = 0; t < 10 && !finalDone; t++) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/tp02_serializer.md
TP02_SERIALIZER -- requirements
Module: tp02_serializer

Interface
REQ-001 Parameter WIDTH, default 4: bits per operand word; legal range 1..16.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift out MSB first; 0 = shift out LSB first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load  input  1  frame request; sampled only in IDLE.
REQ-006 a_data  input  WIDTH  operand word driven onto in1.
REQ-007 b_data  input  WIDTH  operand word driven onto in2.
REQ-008 start  output  1  frame-start marker to TP02, high for exactly one cycle per frame.
REQ-009 in1  output  1  serial bit of a_data.
REQ-010 in2  output  1  serial bit of b_data.
REQ-011 controle  output  1  bit strobe: 0 = bit being set up, 1 = bit valid.
REQ-012 busy  output  1  high from the first cycle after load acceptance through the DONE cycle.
REQ-013 done  output  1  one-cycle pulse after the last strobe of a frame.

Function
REQ-014 FSM states: IDLE, START, SETUP, STROBE, DONE; all outputs registered.
REQ-015 IDLE: load=1 captures a_data/b_data into shift registers, clears bit counter, next = START; load=0 stays IDLE.
REQ-016 START: start=1, controle=0, in1=in2=0; next = SETUP.
REQ-017 SETUP: start=0, controle=0, in1/in2 = current bit of each register; next = STROBE.
REQ-018 STROBE: controle=1, in1/in2 held unchanged from SETUP; if counter = WIDTH-1 next = DONE, else shift both registers, increment counter, next = SETUP.
REQ-019 DONE: done=1, controle=0, in1=in2=0; next = IDLE unconditionally.
REQ-020 Latency: load accepted at edge k -> start high after edge k+1; first in1/in2 valid after edge k+2; done high after edge k+2+2*WIDTH.
REQ-021 Each bit is held for exactly two cycles (controle 0 then 1); in1/in2 never change while controle=1.
REQ-022 load while busy (START..DONE) is ignored; captured data is not disturbed.
REQ-023 load high in the DONE cycle is ignored; a back-to-back frame requires load in the following IDLE cycle.
REQ-024 Counter is ceil(log2(WIDTH+1)) bits wide; WIDTH=1 gives one SETUP/STROBE pair.

Reset
REQ-025 rst_n=0 forces IDLE immediately, regardless of clk.
REQ-026 During reset, and on reset exit: start=in1=in2=controle=busy=done=0; shift registers and counter = 0.
REQ-027 Reset asserted mid-frame aborts the frame; no done pulse is generated.

Configuration
REQ-028 Macro TP02_SER_PARITY_EN defined: after the last data STROBE, one extra SETUP/STROBE pair with in1 = XOR of captured a_data and in2 = XOR of captured b_data (even parity), then DONE; done is delayed by 2 cycles.
REQ-029 TP02_SER_PARITY_EN undefined: no parity pair; timing is exactly as in REQ-020.

Structure
REQ-030 Shared package tp02_pkg holds the state enum (IDLE, START, SETUP, STROBE, DONE) and the default width constant TP02_WIDTH=4.
REQ-031 One sub-module tp02_shreg (WIDTH-bit parallel-load shift register, direction set by MSB_FIRST), instantiated twice, for a_data and b_data.

Verification
REQ-032 Reset: hold rst_n=0 for 3 cycles, release -> all outputs 0, busy=0, FSM in IDLE.
REQ-033 WIDTH=4, MSB_FIRST=1, a=0011, b=1100, one load pulse -> start pulse; in1 = 0,0,1,1 and in2 = 1,1,0,0, each over a controle 0->1 pair; done high 10 cycles after the load edge.
REQ-034 MSB_FIRST=0, a=0001, b=1000 -> in1 = 1,0,0,0; in2 = 0,0,0,1.
REQ-035 Pulse load again during the second bit with a=1111 -> ignored; the frame completes with the original data and only one done pulse.
REQ-036 Drop rst_n during the third STROBE -> outputs 0 asynchronously, no done; a new load after release starts a clean frame.
REQ-037 TP02_SER_PARITY_EN defined, a=0111, b=0101 -> extra pair with in1=1, in2=0; done at cycle 12.
